// File: rtl/matrix_mult_seq_if.sv
// -----------------------------------------------------------------------------
// matrix_mult_seq_if
// Stream interface of the sequential matrix multiplier.
//   in_valid / in_ready / in_data    : element stream of A then B, row-major
//   out_valid / out_ready / out_data : element stream of C, row-major
//   busy                             : block is computing or draining
// Modports:
//   master : the side that feeds elements and consumes results
//   slave  : the multiplier itself
// -----------------------------------------------------------------------------
interface matrix_mult_seq_if #(
    parameter int W  = 4,
    parameter int OW = 9
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/matrix_mult_seq.sv
// -----------------------------------------------------------------------------
// matrix_mult_seq
// Sequential NxN unsigned matrix multiplier C = A * B.
//   LOAD    : accepts 2*N*N elements (A then B, row-major) on in_valid&&in_ready
//   COMPUTE : N^3 cycles, one multiply-accumulate per cycle (k, then j, then i)
//   DRAIN   : streams C row-major under out_valid/out_ready backpressure
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : matrix_mult_seq_if.slave (input stream, output stream, busy)
// Result width OW = 2*W + clog2(N) holds N*(2^W-1)^2 without wrap.
// -----------------------------------------------------------------------------
module matrix_mult_seq #(
    parameter  int N  = 2,
    parameter  int W  = 4,
    localparam int OW = 2 * W + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_mult_seq_if.slave     bus
);

    localparam int CW = $clog2(N);          // i/j/k counter width
    localparam int IW = $clog2(N * N);      // element index width
    localparam int LW = $clog2(2 * N * N);  // load counter width

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic [LW-1:0] load_cnt_r;
    logic [CW-1:0] i_r;
    logic [CW-1:0] j_r;
    logic [CW-1:0] k_r;
    logic [OW-1:0] acc_r;
    logic [IW-1:0] idx_r;
    logic [OW-1:0] out_data_r;
    logic          out_valid_r;
    logic          in_ready_r;
    logic          busy_r;

    logic [W-1:0]  a_mem [N*N];
    logic [W-1:0]  b_mem [N*N];
    logic [OW-1:0] c_mem [N*N];

    logic          accept_s;
    logic          load_last_s;
    logic          k_last_s;
    logic          j_last_s;
    logic          i_last_s;
    logic          comp_last_s;
    logic          xfer_s;
    logic          idx_last_s;
    logic          a_we_s;
    logic          b_we_s;
    logic          c_we_s;
    logic [IW-1:0] a_wr_idx_s;
    logic [IW-1:0] b_wr_idx_s;
    logic [IW-1:0] a_rd_idx_s;
    logic [IW-1:0] b_rd_idx_s;
    logic [IW-1:0] c_wr_idx_s;
    logic [2*W-1:0] prod_s;
    logic [OW-1:0] mac_s;

    // Control decode: handshakes, loop-end flags, memory addressing and the MAC.
    always_comb begin
        accept_s    = 1'b0;
        load_last_s = 1'b0;
        k_last_s    = 1'b0;
        j_last_s    = 1'b0;
        i_last_s    = 1'b0;
        comp_last_s = 1'b0;
        xfer_s      = 1'b0;
        idx_last_s  = 1'b0;
        a_we_s      = 1'b0;
        b_we_s      = 1'b0;
        c_we_s      = 1'b0;
        a_wr_idx_s  = IW'(0);
        b_wr_idx_s  = IW'(0);
        a_rd_idx_s  = IW'(0);
        b_rd_idx_s  = IW'(0);
        c_wr_idx_s  = IW'(0);
        prod_s      = (2*W)'(0);
        mac_s       = OW'(0);

        // Input is only consumed in LOAD; in_valid elsewhere is ignored.
        accept_s    = (state_r == ST_LOAD) && bus.in_valid;
        load_last_s = (load_cnt_r == LW'(2 * N * N - 1));
        a_we_s      = accept_s && (load_cnt_r <  LW'(N * N));
        b_we_s      = accept_s && (load_cnt_r >= LW'(N * N));
        a_wr_idx_s  = IW'(load_cnt_r);
        b_wr_idx_s  = IW'(load_cnt_r - LW'(N * N));

        k_last_s    = (k_r == CW'(N - 1));
        j_last_s    = (j_r == CW'(N - 1));
        i_last_s    = (i_r == CW'(N - 1));
        comp_last_s = (state_r == ST_COMPUTE) && k_last_s && j_last_s && i_last_s;

        a_rd_idx_s  = IW'(i_r) * IW'(N) + IW'(k_r);
        b_rd_idx_s  = IW'(k_r) * IW'(N) + IW'(j_r);
        c_wr_idx_s  = IW'(i_r) * IW'(N) + IW'(j_r);
        prod_s      = (2*W)'(a_mem[a_rd_idx_s]) * (2*W)'(b_mem[b_rd_idx_s]);
        mac_s       = acc_r + OW'(prod_s);
        c_we_s      = (state_r == ST_COMPUTE) && k_last_s;

        xfer_s      = (state_r == ST_DRAIN) && bus.out_ready;
        idx_last_s  = (idx_r == IW'(N * N - 1));
    end

    // Next-state logic of the LOAD -> COMPUTE -> DRAIN sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && load_last_s) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (comp_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && idx_last_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // State register; status outputs are registered from the next state so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_LOAD;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            busy_r      <= (state_nxt_s != ST_LOAD);
        end
    end

    // Counters, accumulator and the registered output element.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_r <= LW'(0);
            i_r        <= CW'(0);
            j_r        <= CW'(0);
            k_r        <= CW'(0);
            acc_r      <= OW'(0);
            idx_r      <= IW'(0);
            out_data_r <= OW'(0);
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) begin
                        load_cnt_r <= load_last_s ? LW'(0) : load_cnt_r + LW'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (k_last_s) begin
                        // C[i][j] takes acc+product this cycle; start the next dot product clean.
                        k_r   <= CW'(0);
                        acc_r <= OW'(0);
                        if (j_last_s) begin
                            j_r <= CW'(0);
                            i_r <= i_last_s ? CW'(0) : i_r + CW'(1);
                        end else begin
                            j_r <= j_r + CW'(1);
                        end
                    end else begin
                        k_r   <= k_r + CW'(1);
                        acc_r <= mac_s;
                    end
                    // C[0] was written long before the final MAC, so it is safe to
                    // present it on the same edge that enters DRAIN.
                    if (comp_last_s) begin
                        out_data_r <= c_mem[IW'(0)];
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) begin
                        if (idx_last_s) begin
                            idx_r <= IW'(0);
                        end else begin
                            idx_r      <= idx_r + IW'(1);
                            out_data_r <= c_mem[idx_r + IW'(1)];
                        end
                    end
                end
                default: begin
                    idx_r <= IW'(0);
                end
            endcase
        end
    end

    // Operand and result storage; contents persist across jobs and are fully
    // rewritten by each job, so no reset is needed.
    always_ff @(posedge clk) begin
        if (a_we_s) begin
            a_mem[a_wr_idx_s] <= bus.in_data;
        end
        if (b_we_s) begin
            b_mem[b_wr_idx_s] <= bus.in_data;
        end
        if (c_we_s) begin
            c_mem[c_wr_idx_s] <= mac_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = busy_r;

endmodule

// File: doc/matrix_mult_seq.md
MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 Parameter N, default 2: matrix dimension (NxN). Legal range 2..8.
REQ-002 Parameter W, default 4: unsigned element width of A and B.
REQ-003 Derived OW = 2*W + clog2(N): result element width; the module SHALL NOT truncate results.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_data holds a valid element.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 in_data  input  W  element of A or B, streamed row-major.
REQ-009 out_valid  output  1  out_data holds a valid C element.
REQ-010 out_ready  input  1  sink accepts out_data this cycle.
REQ-011 out_data  output  OW  element of C, streamed row-major.
REQ-012 busy  output  1  high in COMPUTE and DRAIN.

Function
REQ-013 The FSM SHALL have three states: LOAD, COMPUTE, DRAIN.
REQ-014 In LOAD, in_ready=1; out_valid=0.
REQ-015 In LOAD, an element is accepted on a cycle with in_valid && in_ready.
REQ-016 In LOAD, accepted elements 0..N*N-1 fill A[i][j] and elements N*N..2*N*N-1 fill B[i][j], row-major.
REQ-017 In LOAD, in_valid=0 cycles SHALL be stalls with no state change.
REQ-018 Acceptance of element 2*N*N-1 SHALL move LOAD->COMPUTE at the same edge.
REQ-019 COMPUTE SHALL last exactly N^3 cycles; in_ready=0 and out_valid=0 throughout.
REQ-020 In COMPUTE, one MAC per cycle: acc += A[i][k]*B[k][j], with k innermost, then j, then i, all starting at 0.
REQ-021 When k==N-1, acc+product SHALL be written to C[i][j], and acc SHALL clear to 0 for the next element.
REQ-022 Accumulation SHALL be unsigned at OW bits; for all inputs the maximum result N*(2^W-1)^2 SHALL be representable without wrap.
REQ-023 After the N^3-th COMPUTE cycle the FSM SHALL move to DRAIN.
REQ-024 If the last element is accepted at edge E, out_valid SHALL first be 1 in the cycle following edge E+N^3.
REQ-025 In DRAIN, out_valid=1 and out_data=C[idx], where idx starts at 0 in row-major order.
REQ-026 In DRAIN, idx SHALL advance only on out_valid && out_ready.
REQ-027 While out_ready=0 in DRAIN, out_data and idx SHALL hold stable.
REQ-028 Transfer of idx N*N-1 SHALL return the FSM to LOAD at the same edge; in_ready=1 the next cycle.
REQ-029 There SHALL be no overlap: input SHALL NOT be accepted during COMPUTE or DRAIN; in_valid in those states SHALL be ignored.
REQ-030 A, B and C storage is not cleared between jobs; every job fully overwrites all three.

Reset
REQ-031 rst=1 at a clock edge SHALL set the following, regardless of current state (including mid-LOAD, COMPUTE or DRAIN):
- state=LOAD
- load count, i, j, k, idx and acc = 0
- out_valid=0, busy=0, in_ready=1 in the following cycle
REQ-032 Partially loaded or computed data SHALL be discarded on reset; the next job starts at element 0 of A.
REQ-033 Array contents need not be reset.
REQ-034 out_data is don't-care while out_valid=0.

Verification
REQ-035 N=2, W=4 basic case:
- stimulus: A=[1,2,3,4], B=[5,6,7,8], in_valid held high, out_ready held high
- response: out stream 19,22,43,50
- response: first out_valid exactly 9 cycles after the last input edge (N^3=8 plus 1)
REQ-036 N=2, W=4 maximum values:
- stimulus: all elements 15
- response: every output is 450 (0x1C2, 9 bits), with no truncation
REQ-037 N=3, W=8 identity:
- stimulus: A=identity, B=[1..9]
- response: out stream 1..9
- response: COMPUTE lasts 27 cycles
REQ-038 Backpressure:
- stimulus: out_ready toggled 1,0,0,1,... in DRAIN
- response: each value is held stable while out_ready=0
- response: exactly N*N transfers occur, then in_ready=1
REQ-039 Input stalls and ignored input:
- stimulus: in_valid gaps during LOAD
- response: the results match the gap-free run
- stimulus: in_valid=1 during COMPUTE
- response: in_ready=0 and the input is not consumed
REQ-040 Reset mid-operation:
- stimulus: rst pulsed in COMPUTE cycle 4, then a new job loaded
- response: busy=0 and in_ready=1 in the cycle after the reset edge
- response: the new job produces correct results, with no residue from the aborted job
